serial_sub_ctrl: RTL and testbench

Bit-serial N-bit subtractor controller. It sequences one shared 1-bit full-subtractor cell across WIDTH-bit operands, LSB first, holding the borrow in a flip-flop between bits. A start/busy/done handshake lets a host issue one subtraction at a time. The result is published as a held parallel word plus the final borrow.

---
 rtl/serial_sub_ctrl_if.sv | 24 ++
 rtl/serial_sub_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_ctrl_if.sv
// Host-side handshake and operand/result bundle for the bit-serial subtractor.
// The host drives the request side; the controller drives status and result.
interface serial_sub_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a_in, b_in, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a_in, b_in, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one shared full-subtract cell walks the
// operands LSB first, carrying the borrow in a flop; the result is published on completion.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  serial_sub_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cell_a_c;
  logic             cell_b_c;
  logic             differ_c;
  logic             barrow_c;
  logic [WIDTH-1:0] r_next_c;

  // Single-bit full subtractor over the current LSBs and the held borrow.
  always_comb begin
    cell_a_c = a_sr_q[0];
    cell_b_c = b_sr_q[0];
    differ_c = cell_a_c ^ cell_b_c ^ brw_q;
    barrow_c = (~cell_a_c & cell_b_c) | (~cell_a_c & brw_q) | (cell_b_c & brw_q);
    r_next_c = {differ_c, r_sr_q[WIDTH-1:1]};
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a_in;
          b_sr_d  = bus.b_in;
          brw_d   = bus.bin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        r_sr_d = r_next_c;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        brw_d  = barrow_c;
        cnt_d  = cnt_q + CNT_W'(1);
        // Last bit: the shifted word already includes this edge's difference bit.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d  = r_next_c;
          bout_d  = barrow_c;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl: expected results queue at issue time and
// are popped by a done-monitor; busy length, done width and result hold are tracked.
module tb_serial_sub_ctrl;

  localparam int unsigned WIDTH = 8;

  typedef struct packed {
    logic             bout;
    logic [WIDTH-1:0] diff;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_sub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  res_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bi);
    logic [WIDTH:0] r;
    r = {1'b0, a} - {1'b0, b} - (WIDTH + 1)'(bi);
    return res_t'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Monitor: score results on done, check pulse width, busy length and hold.
  res_t last_res = '0;
  res_t exp_res;
  int   busy_len = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_res  = '0;
      busy_len  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.done) begin
        check("done_one_cycle", 32'(prev_done), 32'd0);
        check("busy_low_in_done", 32'(bus.busy), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_res = exp_q.pop_front();
          check("diff", 32'(bus.diff), 32'(exp_res.diff));
          check("bout", 32'(bus.bout), 32'(exp_res.bout));
          last_res = exp_res;
        end
      end else begin
        check("result_hold", 32'({bus.bout, bus.diff}), 32'(last_res));
      end
      if (bus.busy) begin
        busy_len++;
      end else if (busy_len != 0) begin
        check("busy_len", 32'(busy_len), 32'(WIDTH));
        busy_len = 0;
      end
      prev_done = bus.done;
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) check("done_timeout", 32'd0, 32'd1);
  endtask

  // Issue one op at a negedge in IDLE, scramble inputs after capture, wait for completion.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
    int n;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.bin   = bi;
    bus.start = 1'b1;
    exp_q.push_back(model(a, b, bi));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in  = WIDTH'($urandom);
    bus.b_in  = WIDTH'($urandom);
    bus.bin   = 1'($urandom);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    wait_done(n);
    check("latency", 32'(n), 32'(WIDTH));
    @(negedge clk);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.bin   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and borrow cases.
    run_op(8'h5A, 8'h3C, 1'b0);
    run_op(8'h3C, 8'h5A, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'hFF, 8'h00, 1'b0);

    // Start held high: first op X1, operands swapped to X2 mid-run, re-accepted in IDLE.
    bus.a_in  = 8'hC3;
    bus.b_in  = 8'h15;
    bus.bin   = 1'b1;
    bus.start = 1'b1;
    exp_q.push_back(model(8'hC3, 8'h15, 1'b1));
    exp_q.push_back(model(8'h21, 8'h47, 1'b0));
    repeat (3) @(negedge clk);
    bus.a_in = 8'h21;
    bus.b_in = 8'h47;
    bus.bin  = 1'b0;
    wait_done(n);
    @(negedge clk);
    check("idle_between_ops", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("reaccept_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    // Mid-run pulse with other operands must be ignored.
    bus.start = 1'b1;
    bus.a_in  = 8'h99;
    bus.b_in  = 8'h11;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    repeat (12) @(negedge clk);
    check("no_extra_done", 32'(exp_q.size()), 32'd0);

    // Async reset after three RUN cycles aborts without a done pulse.
    bus.a_in  = 8'h80;
    bus.b_in  = 8'h01;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_diff", 32'(bus.diff), 32'd0);
    check("abort_bout", 32'(bus.bout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'h80, 8'h01, 1'b0);

    // Sweep of 2-bit operand values with both borrow-ins.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          run_op(WIDTH'(a), WIDTH'(b), 1'(bi));
        end
      end
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
